pulse_scheduler: RTL

// - Shares one output strobe line between NUM_REQ requesters.
// - Each requester rising edge is captured as a pending request.
// - Pending requests are served round-robin. Each grant emits one strobe of

---
 rtl/pulse_scheduler.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/pulse_scheduler.sv
// -----------------------------------------------------------------------------
// pulse_scheduler
//
// Shares a single strobe line between NUM_REQ requesters. A rising edge on a
// request level is latched as a pending request. Pending requests are served
// round-robin. Each grant produces a strobe that is high for PULSE_CYCLES
// clocks, followed by a forced low hold-off of GAP_CYCLES clocks.
//
// Ports
//   i_Clk       in   1        clock, rising edge
//   i_Rst_n     in   1        asynchronous active-low reset
//   i_Req       in   NUM_REQ  request levels; a 0->1 edge is one request
//   o_Ack       out  NUM_REQ  one-hot, high for the single grant cycle
//   o_Pulse     out  1        shared strobe
//   o_Grant_Id  out  ID_W     requester owning the current or last strobe
//   o_Busy      out  1        high whenever the scheduler is not idle
// -----------------------------------------------------------------------------
module pulse_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 1,
    localparam int ID_W        = $clog2(NUM_REQ)
) (
    input  logic               i_Clk,
    input  logic               i_Rst_n,
    input  logic [NUM_REQ-1:0] i_Req,
    output logic [NUM_REQ-1:0] o_Ack,
    output logic               o_Pulse,
    output logic [ID_W-1:0]    o_Grant_Id,
    output logic               o_Busy
);

    // Counter only ever holds a value below max(PULSE_CYCLES, GAP_CYCLES).
    localparam int CNT_MAX_V = (PULSE_CYCLES > GAP_CYCLES) ?
                               ((PULSE_CYCLES > 2) ? PULSE_CYCLES : 2) :
                               ((GAP_CYCLES   > 2) ? GAP_CYCLES   : 2);
    localparam int CNT_W     = $clog2(CNT_MAX_V);

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    // With no gap configured the load value is never used.
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PULSE = 2'b01,
        ST_GAP   = 2'b10
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [ID_W-1:0]    rr_last_r;
    logic [NUM_REQ-1:0] req_q_r;
    logic [NUM_REQ-1:0] pending_r;

    logic [NUM_REQ-1:0] rise_s;
    logic [NUM_REQ-1:0] grant_clr_s;
    logic [ID_W-1:0]    sel_s;
    logic [ID_W-1:0]    idx_s;
    logic               found_s;
    logic               start_s;

    // Rising-edge detect on the request levels.
    always_comb begin
        rise_s = i_Req & ~req_q_r;
    end

    // Round-robin search: first pending index after rr_last, wrapping.
    always_comb begin
        sel_s   = {ID_W{1'b0}};
        idx_s   = {ID_W{1'b0}};
        found_s = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx_s   = ID_W'((int'(rr_last_r) + i) % NUM_REQ);
            sel_s   = (!found_s && pending_r[idx_s]) ? idx_s : sel_s;
            found_s = found_s | pending_r[idx_s];
        end
    end

    // A grant is issued only from IDLE with something pending.
    always_comb begin
        start_s     = (state_r == ST_IDLE) && (pending_r != {NUM_REQ{1'b0}});
        grant_clr_s = start_s ? (ONE_HOT0 << sel_s) : {NUM_REQ{1'b0}};
    end

    // Edge capture and pending bookkeeping; a fresh edge wins over the grant clear.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            req_q_r   <= {NUM_REQ{1'b0}};
            pending_r <= {NUM_REQ{1'b0}};
        end else begin
            req_q_r   <= i_Req;
            pending_r <= (pending_r & ~grant_clr_s) | rise_s;
        end
    end

    // Strobe FSM with registered outputs.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            rr_last_r  <= ID_W'(NUM_REQ - 1);
            o_Pulse    <= 1'b0;
            o_Ack      <= {NUM_REQ{1'b0}};
            o_Grant_Id <= {ID_W{1'b0}};
            o_Busy     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r    <= ST_PULSE;
                        cnt_r      <= PULSE_LOAD;
                        rr_last_r  <= sel_s;
                        o_Pulse    <= 1'b1;
                        o_Ack      <= grant_clr_s;
                        o_Grant_Id <= sel_s;
                        o_Busy     <= 1'b1;
                    end else begin
                        o_Pulse <= 1'b0;
                        o_Ack   <= {NUM_REQ{1'b0}};
                        o_Busy  <= 1'b0;
                    end
                end
                ST_PULSE: begin
                    o_Ack <= {NUM_REQ{1'b0}};
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        o_Pulse <= 1'b0;
                        if (GAP_CYCLES == 0) begin
                            state_r <= ST_IDLE;
                            o_Busy  <= 1'b0;
                        end else begin
                            state_r <= ST_GAP;
                            cnt_r   <= GAP_LOAD;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    o_Ack   <= {NUM_REQ{1'b0}};
                    o_Pulse <= 1'b0;
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r <= ST_IDLE;
                        o_Busy  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {CNT_W{1'b0}};
                    o_Pulse <= 1'b0;
                    o_Ack   <= {NUM_REQ{1'b0}};
                    o_Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
